nios2_debug_cmd_sequencer: RTL

- Sits in the CPU clock domain, downstream of the debug-slave sysclk decoder.
- Queues decoded JTAG debug actions and their 38-bit jdo payloads, then issues them one at a time to the OCI memory and break/trace register datapath over a valid/ready command channel.
- Waits for each completion, with a timeout, and drives MonDReg, monitor_ready and monitor_error back toward the debug-slave TCK logic.
- Owns the OCI memory auto-increment address.

---
 rtl/nios2_debug_pkg.sv | 30 +++
 rtl/nios2_debug_cmd_fifo.sv | 58 +++++
 rtl/nios2_debug_cmd_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/nios2_debug_pkg.sv
// Shared types and constants for the Nios II debug command sequencer.
// Action codes mirror the debug-slave sysclk decoder encoding.
package nios2_debug_pkg;

    typedef enum logic [2:0] {
        ACT_OCIMEM_A  = 3'd0,
        ACT_OCIMEM_B  = 3'd1,
        ACT_BREAK_A   = 3'd2,
        ACT_BREAK_B   = 3'd3,
        ACT_BREAK_C   = 3'd4,
        ACT_TRACECTRL = 3'd5
    } act_type_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOCAL,
        ST_ISSUE,
        ST_WAIT_RSP
    } seq_state_e;

    localparam int OCI_ADDR_W  = 9;
    localparam int JDO_ADDR_HI = 10;
    localparam int JDO_ADDR_LO = 2;

    // Codes 6 and 7 have no meaning to the datapath.
    function automatic logic act_is_legal(input logic [2:0] code);
        return code <= 3'd5;
    endfunction

endpackage

// File: rtl/nios2_debug_cmd_fifo.sv
// Synchronous action queue; a push into a full queue is accepted when a pop
// happens in the same cycle.
module nios2_debug_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 41
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/nios2_debug_cmd_sequencer.sv
// Queues decoded JTAG debug actions and issues them one at a time to the OCI
// datapath, reporting completion/timeout back through MonDReg and monitor flags.
module nios2_debug_cmd_sequencer
    import nios2_debug_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int JDO_W          = 38,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  act_valid,
    input  logic [2:0]            act_type,
    input  logic [JDO_W-1:0]      jdo,
    output logic                  act_drop,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [2:0]            cmd_type,
    output logic [OCI_ADDR_W-1:0] cmd_addr,
    output logic [JDO_W-1:0]      cmd_payload,
    input  logic                  rsp_valid,
    input  logic                  rsp_error,
    input  logic [31:0]           rsp_rdata,
    output logic [31:0]           MonDReg,
    output logic                  monitor_ready,
    output logic                  monitor_error,
    output logic                  busy
);

    localparam int ENTRY_W = 3 + JDO_W;
    localparam int TMR_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

    seq_state_e          state;
    seq_state_e          state_next;
    act_type_e           cur_type;
    logic [JDO_W-1:0]    cur_jdo;
    logic [TMR_W-1:0]    timer;

    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic [ENTRY_W-1:0]  fifo_wdata;
    logic [ENTRY_W-1:0]  fifo_rdata;
    act_type_e           head_type;
    logic [JDO_W-1:0]    head_jdo;
    logic                push_ok;
    logic                timed_out;

    assign fifo_wdata = {act_type, jdo};
    assign head_type  = act_type_e'(fifo_rdata[ENTRY_W-1 -: 3]);
    assign head_jdo   = fifo_rdata[JDO_W-1:0];
    assign fifo_pop   = (state == ST_IDLE) && !fifo_empty;
    assign fifo_push  = act_valid && act_is_legal(act_type);
    assign push_ok    = fifo_push && (!fifo_full || fifo_pop);
    assign timed_out  = (timer <= TMR_W'(1));

    assign cmd_type    = cur_type;
    assign cmd_payload = cur_jdo;

    nios2_debug_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wdata   (fifo_wdata),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cmd_valid  = 1'b0;
        busy       = (state != ST_IDLE) || (fifo_count != '0);
        case (state)
            ST_IDLE: begin
                if (fifo_pop) begin
                    state_next = (head_type == ACT_OCIMEM_A) ? ST_LOCAL : ST_ISSUE;
                end
            end
            ST_LOCAL: begin
                state_next = ST_IDLE;
            end
            ST_ISSUE: begin
                cmd_valid = 1'b1;
                if (cmd_ready) begin
                    state_next = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                if (rsp_valid || timed_out) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // A response arriving in the expiry cycle takes priority over the timeout.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            act_drop      <= 1'b0;
            cur_type      <= ACT_OCIMEM_A;
            cur_jdo       <= '0;
            cmd_addr      <= '0;
            timer         <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
        end else begin
            act_drop <= act_valid && !push_ok;
            case (state)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        cur_type      <= head_type;
                        cur_jdo       <= head_jdo;
                        monitor_ready <= 1'b0;
                        monitor_error <= 1'b0;
                    end
                end
                ST_LOCAL: begin
                    cmd_addr      <= cur_jdo[JDO_ADDR_HI:JDO_ADDR_LO];
                    monitor_ready <= 1'b1;
                end
                ST_ISSUE: begin
                    if (cmd_ready) begin
                        timer <= TMR_W'(TIMEOUT_CYCLES);
                        if (cur_type == ACT_OCIMEM_B) begin
                            cmd_addr <= cmd_addr + OCI_ADDR_W'(1);
                        end
                    end
                end
                ST_WAIT_RSP: begin
                    if (rsp_valid) begin
                        MonDReg       <= rsp_rdata;
                        monitor_ready <= 1'b1;
                        monitor_error <= rsp_error;
                        timer         <= '0;
                    end else if (timed_out) begin
                        monitor_ready <= 1'b1;
                        monitor_error <= 1'b1;
                        timer         <= '0;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
